// File: rtl/table_fsm_seq_pkg.sv
// Shared types and sizing helpers for the table-driven sequencer.
// Entry layout is {next_state, out}; table index is {in_sym, state}.
package seq_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_FAULT = 2'd2
    } mode_e;

    localparam int DEF_STATE_W = 3;
    localparam int DEF_IN_W    = 2;
    localparam int DEF_OUT_W   = 3;
    localparam int DEF_CNT_W   = 8;
    localparam int ADDR_W      = DEF_STATE_W + DEF_IN_W;
    localparam int ENTRY_W     = DEF_STATE_W + DEF_OUT_W;

    function automatic int addr_w(input int state_w, input int in_w);
        return state_w + in_w;
    endfunction

    function automatic int entry_w(input int state_w, input int out_w);
        return state_w + out_w;
    endfunction

endpackage

// File: rtl/table_fsm_seq_if.sv
// Control, table-programming and status bundle of the table-driven sequencer.
// The master side drives commands and table writes; the slave side is the sequencer.
interface table_fsm_seq_if
    import seq_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int CNT_W   = DEF_CNT_W
) ();

    localparam int AW = addr_w(STATE_W, IN_W);
    localparam int EW = entry_w(STATE_W, OUT_W);

    logic [IN_W-1:0]    in_sym;
    logic               step;
    logic               start;
    logic               halt;
    logic               clr;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [EW-1:0]      wr_data;
    logic [STATE_W-1:0] state_q;
    logic [OUT_W-1:0]   out_q;
    logic               busy;
    logic               fault;
    logic               wr_err;
    logic [CNT_W-1:0]   steps;

    modport master (
        output in_sym, step, start, halt, clr, wr_en, wr_addr, wr_data,
        input  state_q, out_q, busy, fault, wr_err, steps
    );

    modport slave (
        input  in_sym, step, start, halt, clr, wr_en, wr_addr, wr_data,
        output state_q, out_q, busy, fault, wr_err, steps
    );

endinterface

// File: rtl/table_fsm_seq_fsm_table_mem.sv
// Transition table: one write port, one asynchronous read port, per-entry valid bits.
// Data is not reset; only valid bits clear on res. A same-cycle read sees the old entry.
module fsm_table_mem
    import seq_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic                                 clk,
    input  logic                                 res,
    input  logic                                 we_i,
    input  logic [addr_w(STATE_W, IN_W)-1:0]     waddr_i,
    input  logic [entry_w(STATE_W, OUT_W)-1:0]   wdata_i,
    input  logic [addr_w(STATE_W, IN_W)-1:0]     raddr_i,
    output logic [entry_w(STATE_W, OUT_W)-1:0]   rdata_o,
    output logic                                 rvalid_o
);

    localparam int AW    = addr_w(STATE_W, IN_W);
    localparam int EW    = entry_w(STATE_W, OUT_W);
    localparam int DEPTH = 1 << AW;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Table data write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Valid bits: cleared by reset, set by any write
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign rdata_o  = mem_q[raddr_i];
    assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/table_fsm_seq.sv
// Table-driven sequencer: IDLE/RUN/FAULT mode FSM, state/out registers, saturating step counter.
// Optional SEQ_INPUT_SYNC_EN puts a 2-flop synchroniser in front of the table's symbol address.
module table_fsm_seq
    import seq_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int IN_W        = DEF_IN_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int START_STATE = 0,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic            clk,
    input logic            res,
    table_fsm_seq_if.slave bus
);

    localparam int EW = entry_w(STATE_W, OUT_W);
    localparam logic [STATE_W-1:0] START_S = STATE_W'(START_STATE);

    mode_e              mode_q, mode_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               wr_err_q, wr_err_d;
    logic               we_s;
    logic [IN_W-1:0]    sym_s;
    logic [EW-1:0]      rd_data_s;
    logic               rd_valid_s;
    logic [STATE_W-1:0] nxt_state_s;
    logic [OUT_W-1:0]   nxt_out_s;

`ifdef SEQ_INPUT_SYNC_EN
    logic [IN_W-1:0] sync1_q, sync2_q;

    // Two-flop synchroniser on the input symbol
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.in_sym;
            sync2_q <= sync1_q;
        end
    end

    assign sym_s = sync2_q;
`else
    assign sym_s = bus.in_sym;
`endif

    fsm_table_mem #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) u_mem (
        .clk      (clk),
        .res      (res),
        .we_i     (we_s),
        .waddr_i  (bus.wr_addr),
        .wdata_i  (bus.wr_data),
        .raddr_i  ({sym_s, state_q}),
        .rdata_o  (rd_data_s),
        .rvalid_o (rd_valid_s)
    );

    assign nxt_state_s = rd_data_s[EW-1 -: STATE_W];
    assign nxt_out_s   = rd_data_s[OUT_W-1:0];

    // Mode FSM next-state, table write gating and datapath updates
    always_comb begin
        mode_d   = mode_q;
        state_d  = state_q;
        out_d    = out_q;
        steps_d  = steps_q;
        we_s     = 1'b0;
        wr_err_d = bus.wr_en & (mode_q != MODE_IDLE);
        case (mode_q)
            MODE_IDLE: begin
                we_s = bus.wr_en;
                if (bus.halt) begin
                    mode_d = MODE_IDLE;
                end else if (bus.start) begin
                    mode_d  = MODE_RUN;
                    state_d = START_S;
                    out_d   = '0;
                    steps_d = '0;
                end else begin
                    mode_d = MODE_IDLE;
                end
            end
            MODE_RUN: begin
                if (bus.halt) begin
                    mode_d = MODE_IDLE;
                end else if (bus.step && rd_valid_s) begin
                    state_d = nxt_state_s;
                    out_d   = nxt_out_s;
                    if (steps_q != '1) begin
                        steps_d = steps_q + CNT_W'(1);
                    end else begin
                        steps_d = steps_q;
                    end
                end else if (bus.step) begin
                    mode_d = MODE_FAULT;
                    out_d  = '0;
                end else begin
                    mode_d = MODE_RUN;
                end
            end
            MODE_FAULT: begin
                if (bus.clr) begin
                    mode_d  = MODE_IDLE;
                    state_d = START_S;
                    out_d   = '0;
                end else begin
                    mode_d = MODE_FAULT;
                end
            end
            // An illegal mode encoding is treated as a fault
            default: begin
                mode_d = MODE_FAULT;
                out_d  = '0;
            end
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mode_q   <= MODE_IDLE;
            state_q  <= START_S;
            out_q    <= '0;
            steps_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            state_q  <= state_d;
            out_q    <= out_d;
            steps_q  <= steps_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus.state_q = state_q;
    assign bus.out_q   = out_q;
    assign bus.steps   = steps_q;
    assign bus.wr_err  = wr_err_q;
    assign bus.busy    = (mode_q == MODE_RUN);
    assign bus.fault   = (mode_q == MODE_FAULT);

endmodule
